gray_seq_checker: RTL and testbench

//  Downstream consumer of the 4-bit Gray counter. Samples the Gray code, converts it to

---
 rtl/gray_seq_checker.sv | 128 ++++++++++++
 tb/tb_gray_seq_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_checker.sv
// Gray-code sequence checker: converts sampled Gray to binary and flags non +1/hold steps.
// Optional wrap counter enabled by defining GRAY_CHK_WRAP_CNT_EN.
module gray_seq_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int FAULT_LIMIT = 1
`ifdef GRAY_CHK_WRAP_CNT_EN
    ,
    parameter int WRAP_CNT_W  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 sample_en,
    input  logic                 clear,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 out_valid,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 fault
`ifdef GRAY_CHK_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     MAX_W    = {WIDTH{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ONE_E    = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] MAX_E    = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] LIMIT_E  = ERR_CNT_W'(FAULT_LIMIT);

    state_t                 state, state_next;
    logic [WIDTH-1:0]       nb, prev_bin, prev_bin_next, bin_out_next;
    logic                   out_valid_next, err_pulse_next, wrap_pulse_next;
    logic [ERR_CNT_W-1:0]   err_cnt_next;
`ifdef GRAY_CHK_WRAP_CNT_EN
    localparam logic [WRAP_CNT_W-1:0] ONE_C = {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
    logic [WRAP_CNT_W-1:0]  wrap_cnt_next;
`endif

    // Each binary bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i < WIDTH; i++) begin : g_conv
        assign nb[i] = ^(gray_in >> i);
    end

    always_comb begin
        state_next      = state;
        prev_bin_next   = prev_bin;
        bin_out_next    = bin_out;
        out_valid_next  = 1'b0;
        err_pulse_next  = 1'b0;
        wrap_pulse_next = 1'b0;
        err_cnt_next    = err_cnt;
`ifdef GRAY_CHK_WRAP_CNT_EN
        wrap_cnt_next   = wrap_cnt;
`endif
        if (clear) begin
            state_next   = IDLE;
            err_cnt_next = '0;
`ifdef GRAY_CHK_WRAP_CNT_EN
            wrap_cnt_next = '0;
`endif
        end else if (sample_en) begin
            bin_out_next   = nb;
            prev_bin_next  = nb;
            out_valid_next = 1'b1;
            case (state)
                IDLE: state_next = TRACK;
                TRACK, FAULT: begin
                    if (nb == prev_bin) begin
                        err_pulse_next = 1'b0;
                    end else if (nb == prev_bin + ONE_W) begin
                        wrap_pulse_next = (prev_bin == MAX_W);
                    end else begin
                        err_pulse_next = 1'b1;
                        if (err_cnt != MAX_E) begin
                            err_cnt_next = err_cnt + ONE_E;
                        end
                    end
                    // Once the limit is reached the FSM sticks in FAULT until cleared
                    if (state == FAULT || err_cnt_next >= LIMIT_E) begin
                        state_next = FAULT;
                    end
                end
                default: state_next = IDLE;
            endcase
`ifdef GRAY_CHK_WRAP_CNT_EN
            if (wrap_pulse_next) begin
                wrap_cnt_next = wrap_cnt + ONE_C;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_bin   <= '0;
            bin_out    <= '0;
            out_valid  <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_cnt    <= '0;
            fault      <= 1'b0;
`ifdef GRAY_CHK_WRAP_CNT_EN
            wrap_cnt   <= '0;
`endif
        end else begin
            state      <= state_next;
            prev_bin   <= prev_bin_next;
            bin_out    <= bin_out_next;
            out_valid  <= out_valid_next;
            err_pulse  <= err_pulse_next;
            wrap_pulse <= wrap_pulse_next;
            err_cnt    <= err_cnt_next;
            fault      <= (state_next == FAULT);
`ifdef GRAY_CHK_WRAP_CNT_EN
            wrap_cnt   <= wrap_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Scoreboard bench for gray_seq_checker (WIDTH=4, ERR_CNT_W=8, FAULT_LIMIT=3).
// Honours GRAY_CHK_WRAP_CNT_EN when the design is built with it.
module tb_gray_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] gray_in;
    logic       sample_en;
    logic       clear;
    logic [3:0] bin_out;
    logic       out_valid, err_pulse, wrap_pulse, fault;
    logic [7:0] err_cnt;
`ifdef GRAY_CHK_WRAP_CNT_EN
    logic [7:0] wrap_cnt;
`endif

    always #5 clk = ~clk;

    gray_seq_checker #(
        .WIDTH(4),
        .ERR_CNT_W(8),
        .FAULT_LIMIT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gray_in(gray_in),
        .sample_en(sample_en),
        .clear(clear),
        .bin_out(bin_out),
        .out_valid(out_valid),
        .err_pulse(err_pulse),
        .wrap_pulse(wrap_pulse),
        .err_cnt(err_cnt),
        .fault(fault)
`ifdef GRAY_CHK_WRAP_CNT_EN
        ,
        .wrap_cnt(wrap_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] bin;
        logic       valid;
        logic       err;
        logic       wrap;
        logic [7:0] ecnt;
        logic       flt;
        logic [7:0] wcnt;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state: 0=IDLE 1=TRACK 2=FAULT
    int         m_state = 0;
    int         m_prev = 0, m_bin = 0, m_err = 0, m_wrapcnt = 0;
    logic       m_valid = 0, m_errp = 0, m_wrapp = 0, m_fault = 0;

    function automatic logic [3:0] toGray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    // Inverse found by search so it does not share structure with the design
    function automatic int fromGray(input logic [3:0] g);
        for (int b = 0; b < 16; b++) begin
            if (toGray(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input logic rst, input logic se, input logic clr, input logic [3:0] g);
        int nb;
        m_valid = 0; m_errp = 0; m_wrapp = 0;
        if (rst) begin
            m_state = 0; m_prev = 0; m_bin = 0; m_err = 0; m_wrapcnt = 0;
        end else if (clr) begin
            m_state = 0; m_err = 0; m_wrapcnt = 0;
        end else if (se) begin
            nb = fromGray(g);
            m_valid = 1;
            if (m_state == 0) begin
                m_state = 1;
            end else begin
                if (nb == m_prev) begin
                    m_errp = 0;
                end else if (nb == ((m_prev + 1) % 16)) begin
                    if (m_prev == 15) begin
                        m_wrapp = 1;
                        m_wrapcnt = (m_wrapcnt + 1) % 256;
                    end
                end else begin
                    m_errp = 1;
                    if (m_err < 255) m_err++;
                end
                if (m_err >= 3) m_state = 2;
            end
            m_prev = nb;
            m_bin = nb;
        end
        m_fault = (m_state == 2);
    endtask

    task automatic applyStimulus(input logic rst, input logic se, input logic clr, input logic [3:0] g);
        exp_t e;
        @(negedge clk);
        reset = rst; sample_en = se; clear = clr; gray_in = g;
        modelStep(rst, se, clr, g);
        e.bin = 4'(m_bin); e.valid = m_valid; e.err = m_errp; e.wrap = m_wrapp;
        e.ecnt = 8'(m_err); e.flt = m_fault; e.wcnt = 8'(m_wrapcnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("bin_out", bin_out, e.bin);
            checkOutput("out_valid", out_valid, e.valid);
            checkOutput("err_pulse", err_pulse, e.err);
            checkOutput("wrap_pulse", wrap_pulse, e.wrap);
            checkOutput("err_cnt", err_cnt, e.ecnt);
            checkOutput("fault", fault, e.flt);
`ifdef GRAY_CHK_WRAP_CNT_EN
            checkOutput("wrap_cnt", wrap_cnt, e.wcnt);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; sample_en = 1'b0; clear = 1'b0; gray_in = '0;
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(1, 1, 1, 4'h5);

        // Full count 0..15 then wrap to 0
        for (int b = 0; b < 16; b++) applyStimulus(0, 1, 0, toGray(b));
        applyStimulus(0, 1, 0, toGray(0));
        applyStimulus(0, 0, 0, 4'h0);
        checkOutput("wrap_pulse_seen_err0", err_cnt, 0);

        // Climb to 5 and hold
        for (int b = 1; b <= 5; b++) applyStimulus(0, 1, 0, toGray(b));
        applyStimulus(0, 1, 0, toGray(5));
        applyStimulus(0, 1, 0, toGray(5));

        // Illegal 5->9 then legal 9->10
        applyStimulus(0, 1, 0, toGray(9));
        applyStimulus(0, 1, 0, toGray(10));

        // Fresh error budget, three illegal jumps into FAULT, legal samples keep it
        applyStimulus(0, 0, 1, 4'h0);
        applyStimulus(0, 1, 0, toGray(10));
        applyStimulus(0, 1, 0, toGray(2));
        applyStimulus(0, 1, 0, toGray(7));
        applyStimulus(0, 1, 0, toGray(14));
        applyStimulus(0, 1, 0, toGray(15));
        applyStimulus(0, 1, 0, toGray(0));
        applyStimulus(0, 0, 0, 4'h0);
        applyStimulus(0, 0, 1, 4'h0);
        applyStimulus(0, 0, 0, 4'h0);

        // Clear colliding with a sample
        applyStimulus(0, 1, 0, toGray(0));
        applyStimulus(0, 1, 0, toGray(1));
        applyStimulus(0, 1, 1, toGray(2));
        applyStimulus(0, 1, 0, toGray(7));
        applyStimulus(0, 1, 0, toGray(8));

        // Saturation of the error counter
        for (int k = 0; k < 260; k++) applyStimulus(0, 1, 0, (k % 2 == 0) ? toGray(0) : toGray(8));
        applyStimulus(0, 0, 1, 4'h0);

        // Reset mid-stream, then non-consecutive baseline
        applyStimulus(0, 1, 0, toGray(3));
        applyStimulus(0, 1, 0, toGray(4));
        applyStimulus(1, 1, 0, toGray(5));
        applyStimulus(0, 1, 0, toGray(9));
        applyStimulus(0, 1, 0, toGray(10));
        applyStimulus(0, 1, 0, toGray(13));
        applyStimulus(0, 0, 0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
